ram_port_arbiter: RTL and testbench

//  Shares the single RAM port between NREQ cache-side requesters (index 2c = core c
//  I-cache, 2c+1 = core c D-cache). Round-robin grant, registered request capture,

---
 rtl/ram_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ cache requesters.
// Optional ARB_DATA_PRIO_EN: odd (D-cache) requesters win over even ones.
module ram_port_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_ren,
    input  logic [NREQ-1:0]    req_wen,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_store,
    output logic [NREQ-1:0]    req_wait,
    output logic [DW-1:0]      req_load,
    output logic               ram_ren,
    output logic               ram_wen,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_store,
    input  logic [DW-1:0]      ram_load,
    input  logic               ram_ready,
    output logic               arb_err
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
    localparam logic [DW-1:0] ABORT_DATA = DW'(32'hBAD1BAD1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [GW-1:0]   grant, grant_nx;
    logic [GW-1:0]   rr_ptr, rr_ptr_nx;
    logic            wflag, wflag_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [AW-1:0]   addr_nx;
    logic [DW-1:0]   store_nx;
    logic [DW-1:0]   load_nx;
    logic            err_nx;
    logic            ren_nx, wen_nx;

    logic [NREQ-1:0] active;
    logic [NREQ-1:0] cand;
    logic [GW-1:0]   slot;
    logic [GW-1:0]   pick;
    logic            pick_vld;

    assign active = req_ren | req_wen;

`ifdef ARB_DATA_PRIO_EN
    logic [NREQ-1:0] odd_act;

    always_comb begin
        odd_act = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            odd_act[i] = active[i] & ((i % 2) == 1);
        end
    end

    assign cand = (|odd_act) ? odd_act : active;
`else
    assign cand = active;
`endif

    // First candidate at or after rr_ptr, wrapping mod NREQ.
    always_comb begin
        slot     = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            slot = GW'((32'(rr_ptr) + k) % NREQ);
            if (!pick_vld && cand[slot]) begin
                pick     = slot;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        rr_ptr_nx = rr_ptr;
        wflag_nx  = wflag;
        cnt_nx    = cnt;
        addr_nx   = ram_addr;
        store_nx  = ram_store;
        load_nx   = req_load;
        err_nx    = arb_err;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_nx = pick;
                    addr_nx  = req_addr[32'(pick)*AW +: AW];
                    store_nx = req_store[32'(pick)*DW +: DW];
                    wflag_nx = req_wen[pick];
                    cnt_nx   = '0;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                cnt_nx = cnt + CW'(1);
                if (ram_ready) begin
                    if (!wflag) begin
                        load_nx = ram_load;
                    end
                    state_nx = DONE;
                end else if (cnt_nx == TMO) begin
                    err_nx   = 1'b1;
                    load_nx  = ABORT_DATA;
                    state_nx = DONE;
                end
            end
            DONE: begin
                rr_ptr_nx = (32'(grant) + 1 == NREQ) ? '0 : grant + GW'(1);
                cnt_nx    = '0;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Strobes are registered from the next state so they track ACCESS exactly.
        ren_nx = (state_nx == ACCESS) && !wflag_nx;
        wen_nx = (state_nx == ACCESS) && wflag_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            wflag     <= 1'b0;
            cnt       <= '0;
            ram_addr  <= '0;
            ram_store <= '0;
            req_load  <= '0;
            arb_err   <= 1'b0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
        end else begin
            state     <= state_nx;
            grant     <= grant_nx;
            rr_ptr    <= rr_ptr_nx;
            wflag     <= wflag_nx;
            cnt       <= cnt_nx;
            ram_addr  <= addr_nx;
            ram_store <= store_nx;
            req_load  <= load_nx;
            arb_err   <= err_nx;
            ram_ren   <= ren_nx;
            ram_wen   <= wen_nx;
        end
    end

    // Stall every active requester except the one being released in DONE.
    always_comb begin
        req_wait = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_wait[i] = active[i] & ~((state == DONE) && (grant == GW'(i)));
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed vector table, corner
// sequences and randomized traffic against a transaction-level model.
module tb_ram_port_arbiter;

    localparam int NREQ    = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 255;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_ren = '0;
    logic [NREQ-1:0]    req_wen = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_store = '0;
    logic [NREQ-1:0]    req_wait;
    logic [DW-1:0]      req_load;
    logic               ram_ren, ram_wen;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_store;
    logic [DW-1:0]      ram_load = '0;
    logic               ram_ready = 1'b0;
    logic               arb_err;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    bit chk_en = 1'b0;

    ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_store(req_store),
        .req_wait(req_wait), .req_load(req_load),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_load(ram_load), .ram_ready(ram_ready), .arb_err(arb_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference: one transaction at a time, grant by cyclic search from the pointer.
    function automatic int pick_fn(input logic [NREQ-1:0] act, input int ptr);
`ifdef ARB_DATA_PRIO_EN
        for (int k = 0; k < NREQ; k++)
            if (act[(ptr + k) % NREQ] && (((ptr + k) % NREQ) % 2 == 1)) return (ptr + k) % NREQ;
`endif
        for (int k = 0; k < NREQ; k++)
            if (act[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    int          m_pick;
    bit          m_busy, m_rel, m_wr, m_err;
    int          m_g, m_ptr, m_cnt;
    logic [31:0] m_addr, m_store, m_load;

    always_comb m_pick = pick_fn(req_ren | req_wen, m_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_rel <= 0; m_wr <= 0; m_err <= 0;
            m_g <= 0; m_ptr <= 0; m_cnt <= 0;
            m_addr <= 0; m_store <= 0; m_load <= 0;
        end else if (m_rel) begin
            m_rel <= 0;
            m_ptr <= (m_g + 1) % NREQ;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (ram_ready) begin
                if (!m_wr) m_load <= ram_load;
                m_busy <= 0; m_rel <= 1;
            end else if (m_cnt + 1 == TIMEOUT) begin
                m_err <= 1; m_load <= 32'hBAD1BAD1;
                m_busy <= 0; m_rel <= 1;
            end
        end else if (m_pick >= 0) begin
            m_busy  <= 1; m_g <= m_pick; m_cnt <= 0;
            m_wr    <= req_wen[m_pick];
            m_addr  <= req_addr[m_pick*AW +: AW];
            m_store <= req_store[m_pick*DW +: DW];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next negedge and compare all outputs against the model.
    task automatic tick();
        logic [NREQ-1:0] relmask;
        @(negedge clk);
        #3;
        if (chk_en) begin
            relmask = '0;
            if (m_rel) relmask[m_g] = 1'b1;
            check("model ram_ren", ram_ren, m_busy && !m_wr);
            check("model ram_wen", ram_wen, m_busy && m_wr);
            check("model ram_addr", ram_addr, m_addr);
            check("model ram_store", ram_store, m_store);
            check("model req_load", req_load, m_load);
            check("model arb_err", arb_err, m_err);
            check("model req_wait", req_wait, (req_ren | req_wen) & ~relmask);
        end
    endtask

    task automatic next_grant(output int g, output int at);
        logic prev;
        prev = ram_ren | ram_wen;
        g = -1;
        at = -1;
        for (int n = 0; n < 400; n++) begin
            tick();
            if ((ram_ren | ram_wen) && !prev) begin
                g = int'(ram_addr / 32'h1000) - 1;
                at = cyc_cnt;
                break;
            end
            prev = ram_ren | ram_wen;
        end
    endtask

    task automatic set_addrs();
        for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = 32'h1000 * (i + 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_ren = '0; req_wen = '0; ram_ready = 1'b0;
    endtask

    typedef struct {
        int          idx;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] store;
        int          rdy_at;
        logic [31:0] rload;
        int          exp_ren;
        int          exp_wen;
        int          exp_rel;
        logic [31:0] exp_load;
        bit          exp_err;
    } vec_t;

    vec_t tab[7];

    initial begin
        int nstb, nren, nwen, rel, g, at;
        int gs[5];
        int ats[5];
        int exp_g[5];

        tab[0] = '{1, 1, 0, 32'h40,  32'h0,        2, 32'hDEADBEEF, 2,   0, 4,   32'hDEADBEEF, 1'b0};
        tab[1] = '{0, 1, 0, 32'h80,  32'h0,        1, 32'h0BADF00D, 1,   0, 3,   32'h0BADF00D, 1'b0};
        tab[2] = '{2, 1, 1, 32'hC0,  32'h12345678, 1, 32'hFFFFFFFF, 0,   1, 3,   32'h0BADF00D, 1'b0};
        tab[3] = '{3, 0, 1, 32'h100, 32'hA5A5A5A5, 3, 32'h11111111, 0,   3, 5,   32'h0BADF00D, 1'b0};
        tab[4] = '{3, 1, 0, 32'h140, 32'h0,        4, 32'hCAFEF00D, 4,   0, 6,   32'hCAFEF00D, 1'b0};
        tab[5] = '{1, 1, 0, 32'h180, 32'h0,        0, 32'h77777777, 255, 0, 257, 32'hBAD1BAD1, 1'b1};
        tab[6] = '{0, 1, 0, 32'h1C0, 32'h0,        1, 32'h600DCAFE, 1,   0, 3,   32'h600DCAFE, 1'b1};

        // Reset values
        tick();
        tick();
        check("reset ram_ren", ram_ren, 1'b0);
        check("reset ram_wen", ram_wen, 1'b0);
        check("reset ram_addr", ram_addr, 0);
        check("reset ram_store", ram_store, 0);
        check("reset req_load", req_load, 0);
        check("reset arb_err", arb_err, 1'b0);
        check("reset req_wait", req_wait, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Directed single-requester transactions
        for (int r = 0; r < 7; r++) begin
            req_ren[tab[r].idx] = tab[r].ren;
            req_wen[tab[r].idx] = tab[r].wen;
            req_addr[tab[r].idx*AW +: AW] = tab[r].addr;
            req_store[tab[r].idx*DW +: DW] = tab[r].store;
            ram_load = tab[r].rload;
            ram_ready = 1'b0;
            nstb = 0; nren = 0; nwen = 0; rel = 0;
            for (int c = 2; c <= 400 && rel == 0; c++) begin
                tick();
                if (ram_ren || ram_wen) begin
                    nstb++;
                    ram_ready = (nstb == tab[r].rdy_at);
                end else begin
                    ram_ready = 1'b0;
                end
                nren += int'(ram_ren);
                nwen += int'(ram_wen);
                if (!req_wait[tab[r].idx]) rel = c;
            end
            check($sformatf("row%0d ren cycles", r), nren, tab[r].exp_ren);
            check($sformatf("row%0d wen cycles", r), nwen, tab[r].exp_wen);
            check($sformatf("row%0d release cycle", r), rel, tab[r].exp_rel);
            check($sformatf("row%0d req_load", r), req_load, tab[r].exp_load);
            check($sformatf("row%0d arb_err", r), arb_err, tab[r].exp_err);
            check($sformatf("row%0d ram_addr", r), ram_addr, tab[r].addr);
            if (tab[r].wen) check($sformatf("row%0d ram_store", r), ram_store, tab[r].store);
            req_ren = '0; req_wen = '0; ram_ready = 1'b0;
            tick();
        end

        // Reset in mid-ACCESS, then pending requester 0 goes first
        set_addrs();
        req_ren[2] = 1'b1;
        next_grant(g, at);
        check("rst-seq first grant", g, 2);
        req_ren[0] = 1'b1;
        tick();
        tick();
        check("rst-seq mid access ram_ren", ram_ren, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("async rst ram_ren", ram_ren, 1'b0);
        check("async rst ram_wen", ram_wen, 1'b0);
        check("async rst ram_addr", ram_addr, 0);
        check("async rst ram_store", ram_store, 0);
        check("async rst req_load", req_load, 0);
        check("async rst arb_err", arb_err, 1'b0);
        ram_ready = 1'b1;
        tick();
        rst = 1'b0;
        next_grant(g, at);
        check("rst-seq grant after release", g, 0);
        req_ren = '0;
        repeat (4) tick();

        // All requesters reading continuously with immediate ready
        do_reset();
`ifdef ARB_DATA_PRIO_EN
        exp_g = '{1, 3, 1, 3, 1};
`else
        exp_g = '{0, 1, 2, 3, 0};
`endif
        set_addrs();
        req_ren = '1;
        ram_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            next_grant(gs[k], ats[k]);
            check($sformatf("rr grant %0d", k), gs[k], exp_g[k]);
            if (k > 0) check($sformatf("rr spacing %0d", k), ats[k] - ats[k-1], 3);
        end
        req_ren = '0;
        repeat (4) tick();

        // Requester 3 drops its request mid-ACCESS
        do_reset();
        set_addrs();
        req_ren[3] = 1'b1;
        next_grant(g, at);
        check("drop-seq grant 3", g, 3);
        req_ren[3] = 1'b0;
        req_ren[0] = 1'b1;
        req_ren[2] = 1'b1;
        tick();
        check("drop-seq access continues", ram_ren, 1'b1);
        tick();
        ram_ready = 1'b1;
        next_grant(g, at);
        check("drop-seq next grant", g, 0);
        req_ren = '0;
        repeat (4) tick();

        // Randomized traffic checked cycle by cycle against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if ((req_ren[i] | req_wen[i]) && !req_wait[i]) begin
                    req_ren[i] = 1'b0; req_wen[i] = 1'b0;
                end else if ((req_ren[i] | req_wen[i]) && $urandom_range(63) == 0) begin
                    req_ren[i] = 1'b0; req_wen[i] = 1'b0;
                end else if (!(req_ren[i] | req_wen[i]) && $urandom_range(3) == 0) begin
                    case ($urandom_range(2))
                        0: req_ren[i] = 1'b1;
                        1: req_wen[i] = 1'b1;
                        default: begin req_ren[i] = 1'b1; req_wen[i] = 1'b1; end
                    endcase
                    req_addr[i*AW +: AW] = $urandom;
                    req_store[i*DW +: DW] = $urandom;
                end
            end
            ram_ready = 1'($urandom_range(1));
            ram_load = $urandom;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
